// File: rtl/matrix_scan_ctrl.sv
// LED-matrix scan controller: walks the game-board cells, emitting the memory address and row/col.
// Optional: define MATRIX_SCAN_SERPENTINE_EN for boustrophedon order (odd rows scan right-to-left).
module matrix_scan_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COLS       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned FCNT_W     = 8,
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic              one_shot,
  output logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              busy,
  output logic              blank,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state;
  logic             one_shot_q;
  logic [GAP_W-1:0] gap_cnt;

  logic [ROW_W-1:0] row_nxt_c;
  logic [COL_W-1:0] col_nxt_c;
  logic             last_cell_c;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return BASE_ADDR + ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Position of the next cell in scan order; wraps to (0,0) after the last cell.
  always_comb begin
    row_nxt_c   = row;
    col_nxt_c   = col;
    last_cell_c = 1'b0;
`ifdef MATRIX_SCAN_SERPENTINE_EN
    if (row[0] ? (col == '0) : (col == COL_W'(COLS - 1))) begin
      if (row == ROW_W'(ROWS - 1)) begin
        last_cell_c = 1'b1;
        row_nxt_c   = '0;
        col_nxt_c   = '0;
      end else begin
        row_nxt_c = row + ROW_W'(1);
      end
    end else if (row[0]) begin
      col_nxt_c = col - COL_W'(1);
    end else begin
      col_nxt_c = col + COL_W'(1);
    end
`else
    if (col == COL_W'(COLS - 1)) begin
      col_nxt_c = '0;
      if (row == ROW_W'(ROWS - 1)) begin
        last_cell_c = 1'b1;
        row_nxt_c   = '0;
      end else begin
        row_nxt_c = row + ROW_W'(1);
      end
    end else begin
      col_nxt_c = col + COL_W'(1);
    end
`endif
  end

  // Scan FSM with registered outputs; stop overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      one_shot_q <= 1'b0;
      gap_cnt    <= '0;
      addr       <= BASE_ADDR;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        gap_cnt <= '0;
        addr    <= BASE_ADDR;
        row     <= '0;
        col     <= '0;
        busy    <= 1'b0;
        blank   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state      <= ST_SCAN;
              one_shot_q <= one_shot;
              busy       <= 1'b1;
              blank      <= 1'b0;
            end
          end
          ST_SCAN: begin
            if (enable) begin
              row  <= row_nxt_c;
              col  <= col_nxt_c;
              addr <= cell_addr(row_nxt_c, col_nxt_c);
              if (last_cell_c) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + FCNT_W'(1);
                if (GAP_CYCLES > 0) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
                  blank   <= 1'b1;
                end else if (one_shot_q) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  blank <= 1'b1;
                end
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              gap_cnt <= '0;
              if (one_shot_q) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end else begin
                state <= ST_SCAN;
                blank <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: two geometries driven in lockstep and compared against a cell-index model.
module tb_matrix_scan_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_SCAN = 1;
  localparam int M_GAP  = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic reset, enable, start, stop, one_shot;

  logic [15:0] a_addr, b_addr;
  logic [0:0]  a_row;
  logic [1:0]  a_col;
  logic [1:0]  b_row;
  logic [0:0]  b_col;
  logic        a_busy, a_blank, a_fd, b_busy, b_blank, b_fd;
  logic [1:0]  a_fcnt;
  logic [7:0]  b_fcnt;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(.ADDR_W(16), .ROWS(2), .COLS(4), .BASE_ADDR(16'h0100),
                     .GAP_CYCLES(2), .FCNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .one_shot(one_shot), .addr(a_addr), .row(a_row), .col(a_col), .busy(a_busy),
    .blank(a_blank), .frame_done(a_fd), .frame_cnt(a_fcnt));

  matrix_scan_ctrl #(.ADDR_W(16), .ROWS(3), .COLS(1), .BASE_ADDR(16'hFFFE),
                     .GAP_CYCLES(0), .FCNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .one_shot(one_shot), .addr(b_addr), .row(b_row), .col(b_col), .busy(b_busy),
    .blank(b_blank), .frame_done(b_fd), .frame_cnt(b_fcnt));

  int rows_p[2] = '{2, 3};
  int cols_p[2] = '{4, 1};
  int base_p[2] = '{32'h0100, 32'hFFFE};
  int gap_p[2]  = '{2, 0};
  int fw_p[2]   = '{2, 8};

  // Model state: mode, index of the current cell in scan order, gap clocks left.
  int m_mode[2], m_k[2], m_gap[2], m_fcnt[2], m_fd[2], m_os[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void cell_of(input int i, input int k, output int r, output int c);
    r = k / cols_p[i];
    c = k % cols_p[i];
`ifdef MATRIX_SCAN_SERPENTINE_EN
    if (r % 2 == 1) c = cols_p[i] - 1 - c;
`endif
  endfunction

  task automatic model_step(input int i);
    int ncell;
    ncell = rows_p[i] * cols_p[i];
    if (reset) begin
      m_mode[i] = M_IDLE; m_k[i] = 0; m_gap[i] = 0;
      m_fcnt[i] = 0; m_fd[i] = 0; m_os[i] = 0;
      return;
    end
    m_fd[i] = 0;
    if (stop) begin
      m_mode[i] = M_IDLE; m_k[i] = 0; m_gap[i] = 0;
      return;
    end
    case (m_mode[i])
      M_IDLE, M_DONE: if (start) begin
        m_mode[i] = M_SCAN;
        m_os[i]   = one_shot;
      end
      M_SCAN: if (enable) begin
        if (m_k[i] == ncell - 1) begin
          m_k[i]    = 0;
          m_fd[i]   = 1;
          m_fcnt[i] = (m_fcnt[i] + 1) % (1 << fw_p[i]);
          if (gap_p[i] > 0) begin
            m_mode[i] = M_GAP;
            m_gap[i]  = gap_p[i];
          end else begin
            m_mode[i] = m_os[i] ? M_DONE : M_SCAN;
          end
        end else begin
          m_k[i]++;
        end
      end
      M_GAP: begin
        m_gap[i]--;
        if (m_gap[i] == 0) m_mode[i] = m_os[i] ? M_DONE : M_SCAN;
      end
      default: ;
    endcase
  endtask

  task automatic check_inst(input int i, input string nm, input logic [31:0] addr,
                            input logic [31:0] row, input logic [31:0] col,
                            input logic [31:0] busy, input logic [31:0] blank,
                            input logic [31:0] fd, input logic [31:0] fcnt);
    int r, c;
    cell_of(i, m_k[i], r, c);
    check({nm, "_addr"},  addr,  32'((base_p[i] + r * cols_p[i] + c) & 32'hFFFF));
    check({nm, "_row"},   row,   32'(r));
    check({nm, "_col"},   col,   32'(c));
    check({nm, "_busy"},  busy,  32'(m_mode[i] == M_SCAN || m_mode[i] == M_GAP));
    check({nm, "_blank"}, blank, 32'(m_mode[i] != M_SCAN));
    check({nm, "_fdone"}, fd,    32'(m_fd[i]));
    check({nm, "_fcnt"},  fcnt,  32'(m_fcnt[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_inst(0, "a", 32'(a_addr), 32'(a_row), 32'(a_col), 32'(a_busy), 32'(a_blank),
               32'(a_fd), 32'(a_fcnt));
    check_inst(1, "b", 32'(b_addr), 32'(b_row), 32'(b_col), 32'(b_busy), 32'(b_blank),
               32'(b_fd), 32'(b_fcnt));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Free-run frames with enable held high, including frame counter wrap.
    start = 1'b1; tick(); start = 1'b0;
    enable = 1'b1;
    repeat (52) tick();

    // Enable toggling holds position on low cycles.
    repeat (10) begin enable = ~enable; tick(); end

    // Stop mid-scan, then stop+start together.
    enable = 1'b1; repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0; enable = 1'b0; tick();
    start = 1'b1; stop = 1'b1; tick(); stop = 1'b0; start = 1'b0; tick();

    // One-shot frame, ignored enable in DONE, then restart.
    one_shot = 1'b1; start = 1'b1; tick(); start = 1'b0; one_shot = 1'b0;
    enable = 1'b1; repeat (14) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();

    // Start while scanning is ignored; reset lands mid-gap.
    start = 1'b1; tick(); start = 1'b0; repeat (2) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    reset = 1'b1; tick(); reset = 1'b0; enable = 1'b0; tick();

    // Randomized traffic.
    repeat (3000) begin
      reset    = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 49) == 0);
      enable   = ($urandom_range(0, 9) < 7);
      one_shot = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
